uart_rx_frame_check: RTL and testbench

Parametrised receive-frame checker for the UART RX path. It consumes one mid-bit sample per bit period, after the start bit has been validated upstream, and shifts in DATA_WIDTH data bits LSB-first. It also checks an optional parity bit and 1..MAX_STOP_BITS stop bits, then presents the data word with registered error flags. It sits between the RX edge/bit counter and the RX output register, and generalises the earlier single-stop-bit, combinational-only stop check.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_parity_acc.sv | 35 +++
 rtl/uart_rx_frame_check.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX frame FSM states, parity types and the stop-bit count clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    DONE   = 3'd4
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_type_e;

  // A request of 0 means one stop bit; anything above the supported maximum saturates.
  function automatic logic [1:0] clamp_stop(input logic [1:0] req, input logic [1:0] max_stop);
    logic [1:0] n;
    n = (req == 2'd0) ? 2'd1 : req;
    return (n > max_stop) ? max_stop : n;
  endfunction

endpackage

// File: rtl/uart_parity_acc.sv
// Running XOR parity accumulator with clear/enable; err is the even/odd parity error of acc ^ bit_in.
// With bit_in = 0 and even type, err is the plain running parity, which is what the TX side transmits.
module uart_parity_acc
  import uart_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      clr,
  input  logic      en,
  input  logic      bit_in,
  input  par_type_e par_typ,
  output logic      err
);

  logic acc_q, acc_d;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 1'b0;
    end else if (en) begin
      acc_d = acc_q ^ bit_in;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) acc_q <= 1'b0;
    else     acc_q <= acc_d;
  end

  assign err = (par_typ == PAR_ODD) ? ~(acc_q ^ bit_in) : (acc_q ^ bit_in);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: shifts in LSB-first data, checks optional parity and 1..MAX_STOP_BITS stop bits.
// Optional saturating frame error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_STOP_BITS = 2,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  smp_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [1:0]            stop_num,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [CNT_WIDTH-1:0]  frame_err_cnt
);

  localparam int              BW        = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0]      MAX_STOP  = 2'(MAX_STOP_BITS);
  localparam logic [BW-1:0]   LAST_DATA = BW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic                  par_en_q, par_en_d;
  par_type_e             par_typ_q, par_typ_d;
  logic [1:0]            stop_num_q, stop_num_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_err_nxt_q, par_err_nxt_d;
  logic                  stp_err_nxt_q, stp_err_nxt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  acc_clr, acc_en, acc_err;
  logic [BW-1:0]         stop_last;

  assign stop_last = BW'(stop_num_q) - 1'b1;

  uart_parity_acc u_parity_acc (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (acc_clr),
    .en      (acc_en),
    .bit_in  (sampled_bit),
    .par_typ (par_typ_q),
    .err     (acc_err)
  );

  always_comb begin
    state_d       = state_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    stop_num_d    = stop_num_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_err_nxt_d = par_err_nxt_q;
    stp_err_nxt_d = stp_err_nxt_q;
    data_out_d    = data_out_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    acc_clr       = 1'b0;
    acc_en        = 1'b0;

    // frame_start overrides everything: it aborts a frame in flight and discards a coincident sample.
    if (frame_start) begin
      state_d       = DATA;
      par_en_d      = par_en;
      par_typ_d     = par_type_e'(par_typ);
      stop_num_d    = clamp_stop(stop_num, MAX_STOP);
      bit_cnt_d     = '0;
      shift_d       = '0;
      par_err_nxt_d = 1'b0;
      stp_err_nxt_d = 1'b0;
      par_err_d     = 1'b0;
      stp_err_d     = 1'b0;
      acc_clr       = 1'b1;
    end else begin
      case (state_q)
        DATA: if (smp_valid) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          acc_en  = 1'b1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        PARITY: if (smp_valid) begin
          par_err_nxt_d = acc_err;
          state_d       = STOP;
        end
        STOP: if (smp_valid) begin
          stp_err_nxt_d = stp_err_nxt_q | ~sampled_bit;
          bit_cnt_d     = bit_cnt_q + 1'b1;
          if (bit_cnt_q == stop_last) begin
            // Results are committed on entry to DONE so they are visible alongside data_valid.
            state_d    = DONE;
            data_out_d = shift_q;
            par_err_d  = par_err_nxt_q;
            stp_err_d  = stp_err_nxt_q | ~sampled_bit;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: the data shift register is reset along with the control state so a partial frame never leaks into data_out.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      par_en_q      <= 1'b0;
      par_typ_q     <= PAR_EVEN;
      stop_num_q    <= 2'd1;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_err_nxt_q <= 1'b0;
      stp_err_nxt_q <= 1'b0;
      data_out_q    <= '0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      stop_num_q    <= stop_num_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_err_nxt_q <= par_err_nxt_d;
      stp_err_nxt_q <= stp_err_nxt_d;
      data_out_q    <= data_out_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
    end
  end

  assign busy       = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
  assign data_valid = (state_q == DONE);
  assign data_out   = data_out_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 err_event;

  assign err_event = (state_q == STOP) && (state_d == DONE) && (par_err_d || stp_err_d);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign frame_err_cnt = err_cnt_q;
`else
  assign frame_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Randomised scoreboard bench for uart_rx_frame_check against a frame-level reference model.
module tb_uart_rx_frame_check;

  localparam int DW  = 8;
  localparam int MSB = 2;
  localparam int CW  = 2;
`ifdef UART_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          frame_start = 1'b0;
  logic          smp_valid = 1'b0;
  logic          sampled_bit = 1'b0;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic [1:0]    stop_num = 2'd0;
  logic          busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic [CW-1:0] frame_err_cnt;

  uart_rx_frame_check #(
    .DATA_WIDTH    (DW),
    .MAX_STOP_BITS (MSB),
    .CNT_WIDTH     (CW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .frame_start   (frame_start),
    .smp_valid     (smp_valid),
    .sampled_bit   (sampled_bit),
    .par_en        (par_en),
    .par_typ       (par_typ),
    .stop_num      (stop_num),
    .busy          (busy),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .par_err       (par_err),
    .stp_err       (stp_err),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          se;
    logic [CW-1:0] cnt;
    int unsigned   cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cnt_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every data_valid cycle is matched against the oldest expected frame.
  always @(negedge CLK) begin
    if (data_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_data_valid", 32'(data_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data_out", 32'(data_out), 32'(mon_e.data));
        check("par_err", 32'(par_err), 32'(mon_e.pe));
        check("stp_err", 32'(stp_err), 32'(mon_e.se));
        check("frame_err_cnt", 32'(frame_err_cnt), 32'(mon_e.cnt));
        check("valid_latency_cycle", cyc, mon_e.cyc);
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp(input int n);
    if (n == 0) return 1;
    if (n > MSB) return MSB;
    return n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic sample(input logic b);
    smp_valid   = 1'b1;
    sampled_bit = b;
    tick();
    smp_valid   = 1'b0;
    sampled_bit = 1'($urandom);
  endtask

  // Issue frame_start with a configuration, then scramble the config inputs (they must be latched).
  task automatic start(input logic pe, input logic pt, input logic [1:0] sn, input bit coincide);
    frame_start = 1'b1;
    par_en      = pe;
    par_typ     = pt;
    stop_num    = sn;
    if (coincide) begin
      smp_valid   = 1'b1;
      sampled_bit = 1'($urandom);
    end
    tick();
    frame_start = 1'b0;
    smp_valid   = 1'b0;
    par_en      = 1'($urandom);
    par_typ     = 1'($urandom);
    stop_num    = 2'($urandom);
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [1:0] sn,
                       input logic pbit, input logic [2:0] stops, input bit coincide, input bit gaps);
    int   k;
    logic pe_exp;
    logic se_exp;
    exp_t e;
    start(pe, pt, sn, coincide);
    for (int i = 0; i < DW; i++) begin
      if (gaps) gap();
      sample(d[i]);
    end
    if (pe) begin
      if (gaps) gap();
      sample(pbit);
    end
    k      = clamp(int'(sn));
    se_exp = 1'b0;
    for (int i = 0; i < k; i++) begin
      if (gaps) gap();
      sample(stops[i]);
      if (!stops[i]) se_exp = 1'b1;
    end
    // Even parity: total ones over data+parity must be even; odd parity inverts the verdict.
    pe_exp = pe ? ((^d) ^ pbit ^ pt) : 1'b0;
    if ((pe_exp || se_exp) && cnt_model < (2 ** CW) - 1) cnt_model++;
    e.data = d;
    e.pe   = pe_exp;
    e.se   = se_exp;
    e.cnt  = CNT_EN ? CW'(cnt_model) : '0;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_flags", {30'd0, par_err, stp_err}, 32'd0);
    check("rst_cnt", 32'(frame_err_cnt), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tick();

    // Plain frame, then stray samples in IDLE that must be ignored.
    frame(8'hA5, 1'b0, 1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0);
    tick();
    repeat (3) sample(1'b0);
    check("idle_busy", 32'(busy), 32'd0);

    // Parity: even with wrong/right bit, odd with right bit.
    frame(8'h03, 1'b1, 1'b0, 2'd1, 1'b1, 3'b111, 1'b0, 1'b0);
    frame(8'h03, 1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b1);
    frame(8'h03, 1'b1, 1'b1, 2'd1, 1'b1, 3'b111, 1'b0, 1'b1);

    // Two stop bits, second one bad; flags hold until the next frame_start clears them.
    frame(8'h5A, 1'b0, 1'b0, 2'd2, 1'b0, 3'b101, 1'b0, 1'b0);
    repeat (3) tick();
    check("hold_stp_err", 32'(stp_err), 32'd1);
    check("hold_data_out", 32'(data_out), 32'h5A);
    start(1'b0, 1'b0, 2'd1, 1'b0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_stp_err", 32'(stp_err), 32'd0);
    check("start_keeps_data_out", 32'(data_out), 32'h5A);

    // That frame is aborted after 4 bits; stop_num=3 clamps to 2 stop samples.
    for (int i = 0; i < 4; i++) sample(1'b1);
    frame(8'h3C, 1'b0, 1'b0, 2'd3, 1'b0, 3'b011, 1'b0, 1'b0);
    tick();
    sample(1'b0);
    frame(8'hC3, 1'b1, 1'b1, 2'd0, 1'b1, 3'b001, 1'b1, 1'b1);

    // Reset in the middle of STOP.
    start(1'b0, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < DW; i++) sample(1'($urandom));
    sample(1'b1);
    RST = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_flags", {30'd0, par_err, stp_err}, 32'd0);
    cnt_model = 0;
    tick();
    RST = 1'b0;
    tick();
    frame(8'hFF, 1'b1, 1'b0, 2'd1, 1'b0, 3'b111, 1'b0, 1'b0);

    // Saturating error count: five stop-error frames then a clean one.
    for (int i = 0; i < 5; i++) frame(8'(i * 37), 1'b0, 1'b0, 2'd1, 1'b0, 3'b000, 1'b0, 1'b1);
    frame(8'h81, 1'b0, 1'b0, 2'd2, 1'b0, 3'b011, 1'b0, 1'b0);

    // Randomised frames with occasional aborts, coincident starts and back-to-back starts.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        start(1'($urandom), 1'($urandom), 2'($urandom), 1'b0);
        repeat ($urandom_range(0, DW)) sample(1'($urandom));
      end
      frame(8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            3'($urandom) | (($urandom_range(0, 2) != 0) ? 3'b111 : 3'b000),
            ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 1) == 0) gap();
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
